// File: rtl/exmem_mem_ctrl.sv
// ---------------------------------------------------------------------------
// exmem_mem_ctrl
//
// EX/MEM pipeline register with an integrated data-memory access controller.
// Latches execute-stage results and control bits. Loads and stores run a
// req/done handshake with a variable-latency data memory. While an access is
// outstanding, Stall freezes the upstream stages.
//
// Optional feature macro: EXMEM_TIMEOUT_EN
//   defined   : an ACCESS that lasts TIMEOUT_CYCLES cycles with no mem_done
//               is aborted. ReadData_tomw is zeroed and Err_tomw is set
//               (sticky until reset).
//   undefined : no counter is built; ACCESS waits for mem_done indefinitely
//               and Err_tomw is tied to 0.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   en, flush                advance enable / load-a-bubble request
//   ALUResult, WriteData,
//   PCInc, instructin,
//   WriteReg                 execute-stage data
//   DMemEn, DMemWrite,
//   DMemDump, MemtoReg,
//   PCtoReg, RegWrite, Halt  execute-stage control
//   mem_done, mem_rdata      memory completion strobe and read data
//   mem_req, mem_wr,
//   mem_addr, mem_wdata,
//   mem_dump                 memory request side
//   Stall                    high while an access is outstanding
//   *_tomw, instructout      stage outputs towards MEM/WB
//   Err_tomw                 sticky access-timeout flag
// ---------------------------------------------------------------------------
module exmem_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [15:0] ALUResult,
  input  logic [15:0] WriteData,
  input  logic [15:0] PCInc,
  input  logic [15:0] instructin,
  input  logic [2:0]  WriteReg,
  input  logic        DMemEn,
  input  logic        DMemWrite,
  input  logic        DMemDump,
  input  logic        MemtoReg,
  input  logic        PCtoReg,
  input  logic        RegWrite,
  input  logic        Halt,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_dump,
  output logic        Stall,
  output logic [15:0] ALUResult_tomw,
  output logic [15:0] ReadData_tomw,
  output logic [15:0] PCInc_tomw,
  output logic [15:0] instructout,
  output logic [2:0]  WriteReg_tomw,
  output logic        MemtoReg_tomw,
  output logic        PCtoReg_tomw,
  output logic        RegWrite_tomw,
  output logic        Halt_tomw,
  output logic        Err_tomw
);

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [7:0]  LP_TO     = TIMEOUT_CYCLES[7:0];

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_latch;
  logic        w_access_end;
  logic        w_timeout;
  logic        w_capture;

  logic        r_valid;
  logic [15:0] r_alu;
  logic [15:0] r_wdata;
  logic [15:0] r_pcinc;
  logic [15:0] r_instr;
  logic [2:0]  r_wreg;
  logic        r_dmemwrite;
  logic        r_memtoreg;
  logic        r_pctoreg;
  logic        r_regwrite;
  logic        r_halt;
  logic        r_dump;
  logic [15:0] r_rdata;

`ifdef EXMEM_TIMEOUT_EN
  logic [7:0]  r_cnt;
  logic        r_err;

  // r_cnt holds the number of ACCESS cycles already completed, so a match
  // against LP_TO-1 fires at the end of the LP_TO-th ACCESS cycle.
  assign w_timeout = (r_state == S_ACCESS) & ~mem_done & (r_cnt == LP_TO - 8'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      // Held at zero outside ACCESS and on any exit edge, which also covers
      // the back-to-back re-entry case.
      if (r_state != S_ACCESS || w_access_end) r_cnt <= 8'd0;
      else                                     r_cnt <= r_cnt + 8'd1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign Err_tomw = r_err;
`else
  logic w_unused_to;
  assign w_unused_to = ^LP_TO;
  assign w_timeout   = 1'b0;
  assign Err_tomw    = 1'b0;
`endif

  assign w_access_end = mem_done | w_timeout;
  // Stores leave ReadData_tomw untouched on completion.
  assign w_capture    = (r_state == S_ACCESS) & mem_done & ~r_dmemwrite;

  // Next state / latch decision. The completion edge of an access doubles as
  // a latch edge so back-to-back accesses keep mem_req high.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_latch = 1'b1;
          if (!flush && DMemEn) w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_access_end) begin
          w_state_next = S_IDLE;
          if (en) begin
            w_latch = 1'b1;
            if (!flush && DMemEn) w_state_next = S_ACCESS;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_alu       <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_pcinc     <= 16'h0000;
      r_instr     <= NOP_INSTR;
      r_wreg      <= 3'd0;
      r_dmemwrite <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_pctoreg   <= 1'b0;
      r_regwrite  <= 1'b0;
      r_halt      <= 1'b0;
      r_dump      <= 1'b0;
      r_rdata     <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_dump  <= 1'b0;
      if (w_latch) begin
        if (flush) begin
          r_valid     <= 1'b0;
          r_alu       <= 16'h0000;
          r_wdata     <= 16'h0000;
          r_pcinc     <= 16'h0000;
          r_instr     <= NOP_INSTR;
          r_wreg      <= 3'd0;
          r_dmemwrite <= 1'b0;
          r_memtoreg  <= 1'b0;
          r_pctoreg   <= 1'b0;
          r_regwrite  <= 1'b0;
          r_halt      <= 1'b0;
        end else begin
          r_valid     <= 1'b1;
          r_alu       <= ALUResult;
          r_wdata     <= WriteData;
          r_pcinc     <= PCInc;
          r_instr     <= instructin;
          r_wreg      <= WriteReg;
          r_dmemwrite <= DMemWrite;
          r_memtoreg  <= MemtoReg;
          r_pctoreg   <= PCtoReg;
          r_regwrite  <= RegWrite;
          r_halt      <= Halt;
          r_dump      <= DMemDump;
        end
      end
      if (w_capture)      r_rdata <= mem_rdata;
      else if (w_timeout) r_rdata <= 16'h0000;
    end
  end

  assign mem_req        = (r_state == S_ACCESS);
  assign Stall          = mem_req;
  assign mem_wr         = mem_req & r_dmemwrite;
  assign mem_addr       = r_alu;
  assign mem_wdata      = r_wdata;
  assign mem_dump       = r_dump;
  assign ALUResult_tomw = r_alu;
  assign ReadData_tomw  = r_rdata;
  assign PCInc_tomw     = r_pcinc;
  assign instructout    = r_instr;
  assign WriteReg_tomw  = r_wreg;
  assign MemtoReg_tomw  = r_memtoreg;
  assign PCtoReg_tomw   = r_pctoreg;
  assign RegWrite_tomw  = r_regwrite & r_valid;
  assign Halt_tomw      = r_halt & r_valid;

endmodule

// File: tb/tb_exmem_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exmem_mem_ctrl
//
// Self-checking bench for exmem_mem_ctrl: a vector table for the single-cycle
// pass-through / flush / hold behaviour, plus hand-written sequences for the
// memory handshake, back-to-back stores, reset during an access and timeout.
// ---------------------------------------------------------------------------
module tb_exmem_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [15:0] ALUResult, WriteData, PCInc, instructin;
  logic [2:0]  WriteReg;
  logic        DMemEn, DMemWrite, DMemDump, MemtoReg, PCtoReg, RegWrite, Halt;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_wr, mem_dump, Stall;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] ALUResult_tomw, ReadData_tomw, PCInc_tomw, instructout;
  logic [2:0]  WriteReg_tomw;
  logic        MemtoReg_tomw, PCtoReg_tomw, RegWrite_tomw, Halt_tomw, Err_tomw;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  exmem_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .ALUResult(ALUResult), .WriteData(WriteData), .PCInc(PCInc),
    .instructin(instructin), .WriteReg(WriteReg),
    .DMemEn(DMemEn), .DMemWrite(DMemWrite), .DMemDump(DMemDump),
    .MemtoReg(MemtoReg), .PCtoReg(PCtoReg), .RegWrite(RegWrite), .Halt(Halt),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_dump(mem_dump), .Stall(Stall),
    .ALUResult_tomw(ALUResult_tomw), .ReadData_tomw(ReadData_tomw),
    .PCInc_tomw(PCInc_tomw), .instructout(instructout),
    .WriteReg_tomw(WriteReg_tomw), .MemtoReg_tomw(MemtoReg_tomw),
    .PCtoReg_tomw(PCtoReg_tomw), .RegWrite_tomw(RegWrite_tomw),
    .Halt_tomw(Halt_tomw), .Err_tomw(Err_tomw)
  );

  typedef struct {
    logic        en, flush, dmemen, dmemwrite, dump, rw, halt;
    logic [15:0] alu, instr;
    logic [2:0]  wreg;
    logic [15:0] e_alu, e_instr;
    logic [2:0]  e_wreg;
    logic        e_rw, e_halt, e_dump;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mkv(input logic v_en, v_fl, v_dm, v_dw, v_dump, v_rw, v_h,
                               input logic [15:0] v_alu, v_instr, input logic [2:0] v_wreg,
                               input logic [15:0] x_alu, x_instr, input logic [2:0] x_wreg,
                               input logic x_rw, x_h, x_dump);
    vec_t v;
    v.en = v_en; v.flush = v_fl; v.dmemen = v_dm; v.dmemwrite = v_dw;
    v.dump = v_dump; v.rw = v_rw; v.halt = v_h;
    v.alu = v_alu; v.instr = v_instr; v.wreg = v_wreg;
    v.e_alu = x_alu; v.e_instr = x_instr; v.e_wreg = x_wreg;
    v.e_rw = x_rw; v.e_halt = x_h; v.e_dump = x_dump;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    en = 0; flush = 0; ALUResult = 0; WriteData = 0; PCInc = 0; instructin = 0;
    WriteReg = 0; DMemEn = 0; DMemWrite = 0; DMemDump = 0; MemtoReg = 0;
    PCtoReg = 0; RegWrite = 0; Halt = 0; mem_done = 0; mem_rdata = 0;
  endtask

  // Count Stall-high cycles, strobing mem_done in the k-th one (k=0: never).
  task automatic run_access(input int k, input logic [15:0] rd, input int bound,
                            output int cnt);
    cnt = 0;
    for (int c = 0; c < bound; c++) begin
      if (!Stall) break;
      cnt++;
      mem_done  = (cnt == k);
      mem_rdata = (cnt == k) ? rd : 16'h0000;
      tick();
      mem_done  = 0;
      mem_rdata = 0;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    vecs[0] = mkv(1,0,0,0,0,1,0, 16'h1234,16'h1111,3'd3, 16'h1234,16'h1111,3'd3, 1,0,0);
    vecs[1] = mkv(0,0,0,0,0,0,0, 16'h5555,16'h5555,3'd5, 16'h1234,16'h1111,3'd3, 1,0,0);
    vecs[2] = mkv(1,1,1,1,0,1,1, 16'h9999,16'h3333,3'd6, 16'h0000,16'h0800,3'd0, 0,0,0);
    vecs[3] = mkv(0,0,0,0,0,1,0, 16'h7777,16'h7777,3'd4, 16'h0000,16'h0800,3'd0, 0,0,0);
    vecs[4] = mkv(0,0,0,0,0,1,1, 16'h6666,16'h6666,3'd2, 16'h0000,16'h0800,3'd0, 0,0,0);
    vecs[5] = mkv(1,0,0,0,0,0,1, 16'hABCD,16'h2222,3'd7, 16'hABCD,16'h2222,3'd7, 0,1,0);
    vecs[6] = mkv(1,0,0,0,1,1,0, 16'h0001,16'h4444,3'd1, 16'h0001,16'h4444,3'd1, 1,0,1);
    vecs[7] = mkv(1,0,0,0,0,0,0, 16'h0002,16'h5555,3'd2, 16'h0002,16'h5555,3'd2, 0,0,0);

    // Reset
    @(negedge clk); tick(); tick();
    chk("rst_alu", ALUResult_tomw, 16'h0000);
    chk("rst_rdata", ReadData_tomw, 16'h0000);
    chk("rst_pcinc", PCInc_tomw, 16'h0000);
    chk("rst_instr", instructout, 16'h0800);
    chk("rst_stall", {15'd0, Stall}, 16'd0);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_bits", {10'd0, RegWrite_tomw, Halt_tomw, MemtoReg_tomw, PCtoReg_tomw,
                     mem_dump, Err_tomw}, 16'd0);
    $display("reset: instructout=%h stall=%b", instructout, Stall);
    rst = 1;

    // Table: pass-through, flush of a store, hold, dump pulse
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; flush = vecs[i].flush; DMemEn = vecs[i].dmemen;
      DMemWrite = vecs[i].dmemwrite; DMemDump = vecs[i].dump;
      RegWrite = vecs[i].rw; Halt = vecs[i].halt; ALUResult = vecs[i].alu;
      instructin = vecs[i].instr; WriteReg = vecs[i].wreg;
      tick();
      chk($sformatf("v%0d_alu", i), ALUResult_tomw, vecs[i].e_alu);
      chk($sformatf("v%0d_instr", i), instructout, vecs[i].e_instr);
      chk($sformatf("v%0d_wreg", i), {13'd0, WriteReg_tomw}, {13'd0, vecs[i].e_wreg});
      chk($sformatf("v%0d_rw", i), {15'd0, RegWrite_tomw}, {15'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_halt", i), {15'd0, Halt_tomw}, {15'd0, vecs[i].e_halt});
      chk($sformatf("v%0d_dump", i), {15'd0, mem_dump}, {15'd0, vecs[i].e_dump});
      chk($sformatf("v%0d_req", i), {15'd0, mem_req}, 16'd0);
      chk($sformatf("v%0d_rdata", i), ReadData_tomw, 16'h0000);
      $display("vec %0d: alu=%h instr=%h rw=%b halt=%b dump=%b", i, ALUResult_tomw,
               instructout, RegWrite_tomw, Halt_tomw, mem_dump);
    end
    clear_inputs();

    // mem_done in IDLE is ignored
    mem_done = 1; mem_rdata = 16'h7777;
    tick();
    mem_done = 0; mem_rdata = 0;
    chk("idle_done_stall", {15'd0, Stall}, 16'd0);
    chk("idle_done_rdata", ReadData_tomw, 16'h0000);
    $display("idle mem_done: stall=%b rdata=%h", Stall, ReadData_tomw);

    // Load with 3 wait cycles
    en = 1; DMemEn = 1; ALUResult = 16'h0040; MemtoReg = 1; RegWrite = 1; WriteReg = 3'd2;
    tick();
    clear_inputs();
    chk("ld_addr", mem_addr, 16'h0040);
    chk("ld_wr", {15'd0, mem_wr}, 16'd0);
    chk("ld_req", {15'd0, mem_req}, 16'd1);
    run_access(3, 16'hBEEF, 20, stall_cnt);
    chk("ld_stall_cycles", stall_cnt[15:0], 16'd3);
    chk("ld_rdata", ReadData_tomw, 16'hBEEF);
    chk("ld_req_low", {15'd0, mem_req}, 16'd0);
    $display("load: stall_cycles=%0d rdata=%h", stall_cnt, ReadData_tomw);

    // Back-to-back stores, k=1
    en = 1; DMemEn = 1; DMemWrite = 1; ALUResult = 16'h0010; WriteData = 16'hAAAA;
    tick();
    chk("st1_wr", {15'd0, mem_wr}, 16'd1);
    chk("st1_addr", mem_addr, 16'h0010);
    chk("st1_wdata", mem_wdata, 16'hAAAA);
    mem_done = 1; mem_rdata = 16'h1111; ALUResult = 16'h0012; WriteData = 16'hBBBB;
    tick();
    chk("st2_wr", {15'd0, mem_wr}, 16'd1);
    chk("st2_addr", mem_addr, 16'h0012);
    chk("st2_wdata", mem_wdata, 16'hBBBB);
    chk("st1_rdata_kept", ReadData_tomw, 16'hBEEF);
    mem_done = 1; en = 0; DMemEn = 0; DMemWrite = 0;
    tick();
    clear_inputs();
    chk("st2_stall_low", {15'd0, Stall}, 16'd0);
    chk("st2_wr_low", {15'd0, mem_wr}, 16'd0);
    chk("st2_rdata_kept", ReadData_tomw, 16'hBEEF);
    $display("stores: addr=%h stall=%b rdata=%h", mem_addr, Stall, ReadData_tomw);

    // Reset during ACCESS, then a stray response afterwards
    en = 1; DMemEn = 1; ALUResult = 16'h0020;
    tick();
    clear_inputs();
    chk("rma_stall_hi", {15'd0, Stall}, 16'd1);
    rst = 0;
    tick();
    rst = 1;
    chk("rma_stall", {15'd0, Stall}, 16'd0);
    chk("rma_req", {15'd0, mem_req}, 16'd0);
    chk("rma_instr", instructout, 16'h0800);
    mem_done = 1; mem_rdata = 16'h5A5A;
    tick();
    mem_done = 0; mem_rdata = 0;
    chk("rma_drop", ReadData_tomw, 16'h0000);
    $display("reset mid-access: stall=%b rdata=%h", Stall, ReadData_tomw);

    // Load to get non-zero ReadData, then a load that never completes
    en = 1; DMemEn = 1; ALUResult = 16'h0030;
    tick();
    clear_inputs();
    run_access(1, 16'h1357, 20, stall_cnt);
    chk("pre_to_rdata", ReadData_tomw, 16'h1357);
    en = 1; DMemEn = 1; ALUResult = 16'h0032;
    tick();
    clear_inputs();
    run_access(0, 16'h0000, 20, stall_cnt);
`ifdef EXMEM_TIMEOUT_EN
    chk("to_stall_cycles", stall_cnt[15:0], 16'd4);
    chk("to_stall", {15'd0, Stall}, 16'd0);
    chk("to_err", {15'd0, Err_tomw}, 16'd1);
    chk("to_rdata", ReadData_tomw, 16'h0000);
    tick();
    chk("to_err_sticky", {15'd0, Err_tomw}, 16'd1);
`else
    chk("to_stall_cycles", stall_cnt[15:0], 16'd20);
    chk("to_stall", {15'd0, Stall}, 16'd1);
    chk("to_err", {15'd0, Err_tomw}, 16'd0);
    chk("to_rdata", ReadData_tomw, 16'h1357);
`endif
    $display("timeout: stall_cycles=%0d err=%b rdata=%h", stall_cnt, Err_tomw, ReadData_tomw);
    rst = 0;
    tick();
    rst = 1;
    chk("final_err", {15'd0, Err_tomw}, 16'd0);
    chk("final_stall", {15'd0, Stall}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
